// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths, requester indices and slot record for the writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int AW_DEFAULT = 5;
  localparam int DW_DEFAULT = 32;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  typedef struct packed {
    logic                  full;
    logic                  age;
    logic [AW_DEFAULT-1:0] a3;
    logic [DW_DEFAULT-1:0] wd;
  } slot_t;

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry holding slot for a writeback requester; age=1 marks it younger than its peer.
module rf_wb_slot
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic [AW-1:0] a3,
  input  logic [DW-1:0] wd,
  input  logic          grant,
  input  logic          load_age,
  input  logic          clr_age,
  output logic          ready,
  output logic          load,
  output logic          full,
  output logic          age,
  output logic [AW-1:0] slot_a3,
  output logic [DW-1:0] slot_wd
);

  assign ready = (!full || grant) && !rst;
  // Writes to register 0 are handshaken but never buffered.
  assign load  = valid && ready && (a3 != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 1'b0;
      age     <= 1'b0;
      slot_a3 <= '0;
      slot_wd <= '0;
    end else if (load) begin
      full    <= 1'b1;
      age     <= load_age;
      slot_a3 <= a3;
      slot_wd <= wd;
    end else begin
      if (grant)   full <= 1'b0;
      if (clr_age) age  <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter with registered write port and hazard flags.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_a3,
  input  logic [DW-1:0] alu_wd,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_a3,
  input  logic [DW-1:0] mem_wd,
  output logic          mem_ready,
  output logic          rf_wr,
  output logic [AW-1:0] rf_a3,
  output logic [DW-1:0] rf_wd,
  input  logic [AW-1:0] rd_a1,
  input  logic [AW-1:0] rd_a2,
  output logic          hz1,
  output logic          hz2,
  output logic          idle
);

  logic          alu_full, alu_age, alu_load, alu_grant;
  logic          mem_full, mem_age, mem_load, mem_grant;
  logic [AW-1:0] alu_q_a3, mem_q_a3;
  logic [DW-1:0] alu_q_wd, mem_q_wd;
  logic          last_grant;

  // A new entry is younger whenever its peer still holds an older entry after this edge.
  rf_wb_slot #(.DW(DW), .AW(AW)) u_alu_slot (
    .clk(clk), .rst(rst), .valid(alu_valid), .a3(alu_a3), .wd(alu_wd),
    .grant(alu_grant), .load_age(mem_full && !mem_grant), .clr_age(mem_load),
    .ready(alu_ready), .load(alu_load), .full(alu_full), .age(alu_age),
    .slot_a3(alu_q_a3), .slot_wd(alu_q_wd)
  );

  rf_wb_slot #(.DW(DW), .AW(AW)) u_mem_slot (
    .clk(clk), .rst(rst), .valid(mem_valid), .a3(mem_a3), .wd(mem_wd),
    .grant(mem_grant), .load_age((alu_full && !alu_grant) || alu_load), .clr_age(alu_load),
    .ready(mem_ready), .load(mem_load), .full(mem_full), .age(mem_age),
    .slot_a3(mem_q_a3), .slot_wd(mem_q_wd)
  );

  // Same destination must commit in program order, so age beats round-robin there.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (alu_full && mem_full) begin
      if (alu_q_a3 == mem_q_a3) begin
        if (alu_age) mem_grant = 1'b1;
        else         alu_grant = 1'b1;
      end else if (last_grant == REQ_MEM) begin
        alu_grant = 1'b1;
      end else begin
        mem_grant = 1'b1;
      end
    end else begin
      alu_grant = alu_full;
      mem_grant = mem_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr      <= 1'b0;
      rf_a3      <= '0;
      rf_wd      <= '0;
      last_grant <= REQ_MEM;
    end else if (alu_grant) begin
      rf_wr      <= 1'b1;
      rf_a3      <= alu_q_a3;
      rf_wd      <= alu_q_wd;
      last_grant <= REQ_ALU;
    end else if (mem_grant) begin
      rf_wr      <= 1'b1;
      rf_a3      <= mem_q_a3;
      rf_wd      <= mem_q_wd;
      last_grant <= REQ_MEM;
    end else begin
      rf_wr      <= 1'b0;
    end
  end

  assign hz1 = !rst && (rd_a1 != '0) &&
               ((alu_full && alu_q_a3 == rd_a1) || (mem_full && mem_q_a3 == rd_a1) ||
                (rf_wr && rf_a3 == rd_a1));
  assign hz2 = !rst && (rd_a2 != '0) &&
               ((alu_full && alu_q_a3 == rd_a2) || (mem_full && mem_q_a3 == rd_a2) ||
                (rf_wr && rf_a3 == rd_a2));

  assign idle = !alu_full && !mem_full && !rf_wr;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and randomized checks of rf_wb_arbiter against a sequence-numbered queue model.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_a3, mem_a3, rd_a1, rd_a2;
  logic [31:0] alu_wd, mem_wd;
  logic        alu_ready, mem_ready, rf_wr, hz1, hz2, idle;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;

  int vectors = 0;
  int miscompares = 0;

  // Model: each pending entry carries a global sequence number so "older" is a plain compare.
  bit          m_full [2];
  logic [4:0]  m_a3   [2];
  logic [31:0] m_wd   [2];
  int          m_seq  [2];
  int          seqCtr;
  int          m_last;
  logic        m_rfwr;
  logic [4:0]  m_rfa3;
  logic [31:0] m_rfwd;
  int          g;
  logic        expRdy [2];
  logic [31:0] dutRegs [32];

  rf_wb_arbiter #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_a3(alu_a3), .alu_wd(alu_wd), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_a3(mem_a3), .mem_wd(mem_wd), .mem_ready(mem_ready),
    .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .hz1(hz1), .hz2(hz2), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0; m_a3[i] = '0; m_wd[i] = '0; m_seq[i] = 0;
    end
    m_last = 1; m_rfwr = 0; m_rfa3 = '0; m_rfwd = '0;
  endtask

  function automatic int pickGrant();
    if (m_full[0] && m_full[1]) begin
      if (m_a3[0] == m_a3[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
      return (m_last == 0) ? 1 : 0;
    end
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic logic hzExp(input logic [4:0] ra);
    if (rst || ra == 0) return 1'b0;
    return (m_full[0] && m_a3[0] == ra) || (m_full[1] && m_a3[1] == ra) ||
           (m_rfwr && m_rfa3 == ra);
  endfunction

  task automatic applyStimulus(input logic r, input logic av, input logic [4:0] aa,
                               input logic [31:0] aw, input logic mv, input logic [4:0] ma,
                               input logic [31:0] mw, input logic [4:0] r1, input logic [4:0] r2);
    rst = r; alu_valid = av; alu_a3 = aa; alu_wd = aw;
    mem_valid = mv; mem_a3 = ma; mem_wd = mw; rd_a1 = r1; rd_a2 = r2;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic checkOutput();
    g = pickGrant();
    for (int i = 0; i < 2; i++) expRdy[i] = !rst && (!m_full[i] || g == i);
    chk("alu_ready", alu_ready, expRdy[0]);
    chk("mem_ready", mem_ready, expRdy[1]);
    chk("rf_wr", rf_wr, m_rfwr);
    chk("rf_a3", rf_a3, m_rfa3);
    chk("rf_wd", rf_wd, m_rfwd);
    chk("hz1", hz1, hzExp(rd_a1));
    chk("hz2", hz2, hzExp(rd_a2));
    chk("idle", idle, !m_full[0] && !m_full[1] && !m_rfwr);
    if (rf_wr === 1'b1) dutRegs[rf_a3] = rf_wd;
  endtask

  task automatic finishCycle();
    logic       v [2];
    logic [4:0] a [2];
    logic [31:0] d [2];
    v[0] = alu_valid; a[0] = alu_a3; d[0] = alu_wd;
    v[1] = mem_valid; a[1] = mem_a3; d[1] = mem_wd;
    if (rst) begin
      modelReset();
    end else begin
      if (g >= 0) begin
        m_rfwr = 1; m_rfa3 = m_a3[g]; m_rfwd = m_wd[g]; m_last = g; m_full[g] = 0;
      end else begin
        m_rfwr = 0;
      end
      for (int i = 0; i < 2; i++) begin
        if (v[i] && expRdy[i] && a[i] != 0) begin
          m_full[i] = 1; m_a3[i] = a[i]; m_wd[i] = d[i]; m_seq[i] = seqCtr;
          seqCtr++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input logic [4:0] r1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, r1, 0);
    finishCycle();
  endtask

  initial begin
    int ai, mi, wrCount;
    seqCtr = 1;
    for (int i = 0; i < 32; i++) dutRegs[i] = '0;
    rst = 1; alu_valid = 0; mem_valid = 0; alu_a3 = 0; mem_a3 = 0;
    alu_wd = 0; mem_wd = 0; rd_a1 = 0; rd_a2 = 0;
    @(posedge clk); #1;
    modelReset();

    applyStimulus(1, 1, 5, 32'h1, 1, 6, 32'h2, 5, 6);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    finishCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_idle", idle, 1);
    finishCycle();

    // Single write: latency two and hazard window t+1..t+2
    applyStimulus(0, 1, 5, 32'h12345678, 0, 0, 0, 5, 0);
    chk("single_hz_t0", hz1, 0);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);
    chk("single_hz_t1", hz1, 1);
    chk("single_wr_t1", rf_wr, 0);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);
    chk("single_wr_t2", rf_wr, 1);
    chk("single_a3_t2", rf_a3, 5);
    chk("single_wd_t2", rf_wd, 32'h12345678);
    chk("single_hz_t2", hz1, 1);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 0);
    chk("single_wr_t3", rf_wr, 0);
    chk("single_hz_t3", hz1, 0);
    finishCycle();

    // Simultaneous distinct destinations right after reset: ALU first
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); finishCycle();
    applyStimulus(0, 1, 3, 32'hA, 1, 4, 32'hB, 0, 0); finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 3, 4);
    chk("dist_mem_ready_t1", mem_ready, 0);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("dist_a3_t2", rf_a3, 3);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("dist_a3_t3", rf_a3, 4);
    chk("dist_wd_t3", rf_wd, 32'hB);
    finishCycle();

    // Same destination: program order preserved
    applyStimulus(0, 1, 7, 32'h1, 1, 7, 32'h2, 7, 0); finishCycle();
    idleCycle(7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("same_wd_first", rf_wd, 32'h1);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 7, 0);
    chk("same_wd_second", rf_wd, 32'h2);
    finishCycle();
    idleCycle(0);
    chk("same_final_reg7", dutRegs[7], 32'h2);

    // Write to register 0 is swallowed
    applyStimulus(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
    chk("zero_mem_ready", mem_ready, 1);
    chk("zero_idle_t0", idle, 1);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("zero_rf_wr", rf_wr, 0);
    chk("zero_hz1", hz1, 0);
    chk("zero_idle_t1", idle, 1);
    finishCycle();

    // Continuous streaming from both requesters
    ai = 0; mi = 0; wrCount = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 1, 5'(16 + ai), $urandom, 1, 5'(24 + mi), $urandom,
                    5'(16 + ai), 5'(24 + mi));
      if (k >= 2 && rf_wr === 1'b1) wrCount++;
      if (expRdy[0]) ai++;
      if (expRdy[1]) mi++;
      finishCycle();
    end
    chk("stream_rate", wrCount, 6);
    for (int k = 0; k < 4; k++) idleCycle(0);

    // Reset with both slots full discards them
    applyStimulus(0, 1, 9, 32'hDEAD0009, 1, 10, 32'hDEAD000A, 9, 10); finishCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 9, 10);
    chk("rmid_alu_ready", alu_ready, 0);
    chk("rmid_mem_ready", mem_ready, 0);
    chk("rmid_hz1", hz1, 0);
    finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 9, 10);
    chk("rmid_rf_wr", rf_wr, 0);
    chk("rmid_idle", idle, 1);
    chk("rmid_ready_after", {alu_ready, mem_ready}, 2'b11);
    finishCycle();
    for (int k = 0; k < 3; k++) idleCycle(9);
    chk("rmid_no_write9", dutRegs[9] === 32'hDEAD0009, 0);
    chk("rmid_no_write10", dutRegs[10] === 32'hDEAD000A, 0);

    // Randomized traffic with small address range to force collisions and zeros
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 39) == 0,
                    $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      finishCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
